mem_port_arb: RTL

- Arbitrates the single core memory port between instruction fetch (IF) and the exe-stage load/store unit (LSU).
- One outstanding transaction at a time, with a simple valid/ready request channel and a valid-only response channel.
- LSU has priority, with an anti-starvation counter that guarantees IF progress.
- Honours the exe-stage flush so that instruction responses in flight after a taken branch are discarded.

---
 rtl/mem_port_arb_pkg.sv | 14 +
 rtl/mem_port_arb.sv | 101 ++++++++++
 2 files changed

// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: shared width, state encoding and size codes for the memory port arbiter
package mem_port_arb_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LSU
    } arb_state_t;

endpackage

// File: rtl/mem_port_arb.sv
// mem_port_arb: single-outstanding arbiter of the core memory port between fetch and LSU
module mem_port_arb #(
    parameter int XLEN       = mem_port_arb_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_v_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rsp_v_o,
    output logic [XLEN-1:0] if_rsp_data_o,
    input  logic            lsu_req_v_i,
    input  logic [XLEN-1:0] lsu_adr_i,
    input  logic            lsu_is_store_i,
    input  logic [XLEN-1:0] lsu_store_data_i,
    input  logic [2:0]      lsu_access_size_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rsp_v_o,
    output logic [XLEN-1:0] lsu_rsp_data_o,
    input  logic            flush_v_i,
    output logic            mem_req_v_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_req_rdy_i,
    input  logic            mem_rsp_v_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            err_o
);

    import mem_port_arb_pkg::*;

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       discard_q;
    logic       store_q;
    logic       idle;
    logic       if_ok;
    logic       lsu_sel;
    logic       if_done;
    logic       lsu_done;

    // Selection, grants and the request mux; a flushed fetch never reaches the port
    always_comb begin
        idle        = state == IDLE;
        if_ok       = if_req_v_i & ~flush_v_i;
        lsu_sel     = lsu_req_v_i & ~(if_ok & (starve_cnt == 4'(STARVE_MAX)));
        mem_req_v_o = idle & (lsu_req_v_i | if_ok);
        lsu_gnt_o   = idle & lsu_sel & mem_req_rdy_i;
        if_gnt_o    = idle & ~lsu_sel & if_ok & mem_req_rdy_i;
        mem_adr_o   = lsu_sel ? lsu_adr_i : if_adr_i;
        mem_we_o    = lsu_sel & lsu_is_store_i;
        mem_wdata_o = lsu_sel ? lsu_store_data_i : '0;
        mem_size_o  = lsu_sel ? lsu_access_size_i : SIZE_WORD;
        if_done     = (state == BUSY_IF) & mem_rsp_v_i & ~discard_q & ~flush_v_i;
        lsu_done    = (state == BUSY_LSU) & mem_rsp_v_i;
    end

    // Transaction FSM, anti-starvation counter, registered responses and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            discard_q      <= 1'b0;
            store_q        <= 1'b0;
            err_o          <= 1'b0;
            if_rsp_v_o     <= 1'b0;
            lsu_rsp_v_o    <= 1'b0;
            if_rsp_data_o  <= '0;
            lsu_rsp_data_o <= '0;
        end else begin
            err_o       <= err_o | (idle & mem_rsp_v_i);
            if_rsp_v_o  <= if_done;
            lsu_rsp_v_o <= lsu_done;
            if (if_done)
                if_rsp_data_o <= mem_rsp_data_i;
            if (lsu_done)
                lsu_rsp_data_o <= store_q ? '0 : mem_rsp_data_i;
            if (!if_req_v_i || if_gnt_o)
                starve_cnt <= '0;
            else if (lsu_gnt_o && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
            if (state == BUSY_IF)
                discard_q <= mem_rsp_v_i ? 1'b0 : (discard_q | flush_v_i);
            case (state)
                IDLE: begin
                    if (lsu_gnt_o) begin
                        state   <= BUSY_LSU;
                        store_q <= lsu_is_store_i;
                    end else if (if_gnt_o) begin
                        state <= BUSY_IF;
                    end
                end
                default: if (mem_rsp_v_i) state <= IDLE;
            endcase
        end
    end

endmodule
